// File: rtl/mux_4x1.sv
// Registered 4-to-1 lane multiplexer.
// Lane s of the input bus is captured into y every clock edge.
module mux_4x1 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4*WIDTH-1:0] in,
  input  logic [1:0]         s,
  output logic [WIDTH-1:0]   y
);

  logic [WIDTH-1:0] lane [4];
  logic [WIDTH-1:0] sel;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign lane[k] = in[k*WIDTH +: WIDTH];
  end

  // An unknown select reads the array out of range, giving X in simulation.
  assign sel = lane[s];

  always_ff @(posedge clk) begin
    if (rst) y <= '0;
    else     y <= sel;
  end

endmodule

// File: tb/tb_mux_4x1.sv
// Self-checking bench for mux_4x1.
// Directed steps followed by randomized steps against a reference model.
module tb_mux_4x1;

  logic       clk;
  logic       rst;
  logic [3:0] in;
  logic [1:0] s;
  logic       y;

  int checks = 0;
  int errors = 0;

  mux_4x1 #(.WIDTH(1)) dut (
    .clk(clk),
    .rst(rst),
    .in (in),
    .s  (s),
    .y  (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model(logic r, logic [3:0] i, logic [1:0] sel);
    int v;
    if (r) return 1'b0;
    v = (int'(i) / (2 ** int'(sel))) % 2;
    return v[0];
  endfunction

  task automatic check(string tag, logic exp);
    checks++;
    assert (y === exp) else begin
      errors++;
      $error("FAIL %s y=%b expected=%b", tag, y, exp);
    end
  endtask

  task automatic step(string tag, logic r, logic [3:0] i, logic [1:0] sel);
    rst = r;
    in  = i;
    s   = sel;
    @(posedge clk);
    #1;
    check(tag, model(r, i, sel));
  endtask

  initial begin
    rst = 1'b1;
    in  = 4'b1111;
    s   = 2'b11;

    step("rst0", 1'b1, 4'b1111, 2'b11);
    step("rst1", 1'b1, 4'b1111, 2'b11);
    step("rst_rel", 1'b0, 4'b1111, 2'b11);

    step("sweep0", 1'b0, 4'b0001, 2'b00);
    step("sweep1", 1'b0, 4'b0010, 2'b01);
    step("sweep2", 1'b0, 4'b0100, 2'b10);
    step("sweep3", 1'b0, 4'b1000, 2'b11);

    step("iso0", 1'b0, 4'b0101, 2'b01);
    step("iso1", 1'b0, 4'b0100, 2'b01);
    step("iso2", 1'b0, 4'b0001, 2'b01);
    step("iso3", 1'b0, 4'b1101, 2'b01);
    step("iso4", 1'b0, 4'b1000, 2'b01);

    step("mix0", 1'b0, 4'b0111, 2'b10);
    step("mix1", 1'b0, 4'b1100, 2'b11);
    step("mix2", 1'b0, 4'b0101, 2'b00);
    for (int k = 0; k < 4; k++)
      step("zero", 1'b0, 4'b0000, 2'(k));

    // Select change mid-cycle must not reach y before the next edge.
    step("lat_pre", 1'b0, 4'b1000, 2'b00);
    #3;
    s = 2'b11;
    #1;
    check("lat_mid0", 1'b0);
    #4;
    check("lat_mid1", 1'b0);
    @(posedge clk);
    #1;
    check("lat_post", 1'b1);

    step("mid_hold", 1'b0, 4'b1000, 2'b11);
    step("mid_rst", 1'b1, 4'b1000, 2'b11);
    step("mid_rel", 1'b0, 4'b1000, 2'b11);

    for (int n = 0; n < 60; n++) begin
      logic       r;
      logic [3:0] i;
      logic [1:0] sel;
      r   = ($urandom_range(0, 9) == 0);
      i   = 4'($urandom);
      sel = 2'($urandom);
      step("rand", r, i, sel);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
